// File: rtl/prn_permutation_gen_if.sv
// Output stream handshake for the permutation generator.
// The master drives the element; the slave accepts it.
interface prn_permutation_gen_if #(
    parameter int IDX_W = 4
);
    logic             out_valid_o;
    logic             out_ready_i;
    logic [IDX_W-1:0] out_data_o;
    logic             out_last_o;

    modport master (
        output out_valid_o,
        output out_data_o,
        output out_last_o,
        input  out_ready_i
    );

    modport slave (
        input  out_valid_o,
        input  out_data_o,
        input  out_last_o,
        output out_ready_i
    );
endinterface

// File: rtl/prn_permutation_gen.sv
// Fisher-Yates permutation generator driven by xorshift-32.
// Streams the shuffled table one element per handshake.
module prn_permutation_gen #(
    parameter int N_ELEM = 10,
    parameter int IDX_W  = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] seed_i,
    output logic        busy_o,
    output logic        done_o,
    prn_permutation_gen_if.master out
);
    typedef enum logic [1:0] {
        IDLE,
        SHUFFLE,
        EMIT
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ELEM - 1);
    localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

    state_t           state;
    logic [31:0]      s;
    logic [IDX_W-1:0] i;
    logic [IDX_W-1:0] p;
    logic [IDX_W-1:0] tbl [N_ELEM];

    logic [31:0]      xs_r;
    logic [31:0]      div;
    logic [IDX_W-1:0] j;
    logic [IDX_W-1:0] p_nxt;
    logic [IDX_W-1:0] first;

    function automatic logic [31:0] xs(input logic [31:0] v);
        logic [31:0] t;
        t = v ^ (v << 13);
        t = t ^ (t >> 7);
        t = t ^ (t << 17);
        return t;
    endfunction

    // Next PRNG value, swap partner, emit pointer and the
    // element landing in slot 0 after the final swap.
    always_comb begin
        xs_r  = xs(s);
        div   = 32'(i) + 32'd1;
        j     = IDX_W'(xs_r % div);
        p_nxt = p + ONE;
        first = (j == '0) ? tbl[1] : tbl[0];
    end

    assign busy_o = (state != IDLE);

    // Control FSM, shuffle datapath and registered stream outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= IDLE;
            s               <= '0;
            i               <= LAST;
            p               <= '0;
            done_o          <= 1'b0;
            out.out_valid_o <= 1'b0;
            out.out_last_o  <= 1'b0;
            out.out_data_o  <= '0;
            for (int k = 0; k < N_ELEM; k++) begin
                tbl[k] <= IDX_W'(k);
            end
        end else begin
            done_o <= 1'b0;
            if (abort_i) begin
                state           <= IDLE;
                out.out_valid_o <= 1'b0;
                out.out_last_o  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start_i) begin
                            for (int k = 0; k < N_ELEM; k++) begin
                                tbl[k] <= IDX_W'(k);
                            end
                            s     <= (seed_i == '0) ? 32'h1 : seed_i;
                            i     <= LAST;
                            p     <= '0;
                            state <= SHUFFLE;
                        end
                    end
                    SHUFFLE: begin
                        s      <= xs_r;
                        tbl[i] <= tbl[j];
                        tbl[j] <= tbl[i];
                        if (i == ONE) begin
                            state           <= EMIT;
                            out.out_valid_o <= 1'b1;
                            out.out_data_o  <= first;
                            out.out_last_o  <= 1'b0;
                        end else begin
                            i <= i - ONE;
                        end
                    end
                    EMIT: begin
                        if (out.out_ready_i) begin
                            p <= p_nxt;
                            if (p == LAST) begin
                                out.out_valid_o <= 1'b0;
                                out.out_last_o  <= 1'b0;
                                done_o          <= 1'b1;
                                state           <= IDLE;
                            end else begin
                                out.out_data_o <= tbl[p_nxt];
                                out.out_last_o <= (p_nxt == LAST);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
